// File: rtl/bp_poll_pkg.sv
// rtl/bp_poll_pkg.sv - shared types and parameter limits for the push-button poll master
package bp_poll_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2
  } poll_state_t;

  localparam int MIN_POLL_PERIOD    = 4;
  localparam int MIN_READ_LATENCY   = 1;
  localparam int MAX_READ_LATENCY   = 4;
  localparam int MIN_DEBOUNCE_COUNT = 2;
  localparam int MAX_DEBOUNCE_COUNT = 255;

  // Wide enough for MAX_READ_LATENCY.
  localparam int LAT_W = 3;

endpackage

// File: rtl/bp_debounce.sv
// rtl/bp_debounce.sv - sample-count debouncer producing pressed state and edge pulses
module bp_debounce
  import bp_poll_pkg::*;
#(
  parameter int NBTN           = 2,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            strobe,
  input  logic [NBTN-1:0] sample,
  output logic [NBTN-1:0] btn_state,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release
);

  localparam int            CW   = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_COUNT);

  if (DEBOUNCE_COUNT < MIN_DEBOUNCE_COUNT || DEBOUNCE_COUNT > MAX_DEBOUNCE_COUNT) begin : g_bad_count
    $error("bp_debounce: DEBOUNCE_COUNT out of range");
  end

  logic [NBTN-1:0] candidate;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;

  // A differing sample restarts the run; an equal one extends it, saturating at FULL.
  always_comb begin
    count_next = count;
    if (sample != candidate) begin
      count_next = CW'(1);
    end else if (count < FULL) begin
      count_next = count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      candidate   <= '0;
      count       <= '0;
      btn_state   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_press   <= '0;
      btn_release <= '0;
      if (strobe) begin
        candidate <= sample;
        count     <= count_next;
        if (count_next == FULL && sample != btn_state) begin
          btn_state   <= sample;
          btn_press   <= sample & ~btn_state;
          btn_release <= btn_state & ~sample;
        end
      end
    end
  end

endmodule

// File: rtl/bp_poll_master.sv
// rtl/bp_poll_master.sv - Avalon-MM master polling the button PIO and emitting debounced events
module bp_poll_master
  import bp_poll_pkg::*;
#(
  parameter int POLL_PERIOD    = 50000,
  parameter int READ_LATENCY   = 1,
  parameter int DEBOUNCE_COUNT = 4,
  parameter int BASE_ADDR      = 0,
  parameter int ADDR_W         = 2,
  parameter int NBTN           = 2,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [NBTN-1:0]   btn_state,
  output logic [NBTN-1:0]   btn_press,
  output logic [NBTN-1:0]   btn_release,
  output logic              sample_valid,
  output logic              overrun
);

  localparam int               TW           = $clog2(POLL_PERIOD);
  localparam logic [TW-1:0]    TIMER_RELOAD = TW'(POLL_PERIOD - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD     = LAT_W'(READ_LATENCY);
  localparam logic [NBTN-1:0]  POLARITY     = {NBTN{ACTIVE_LOW}};

  if (POLL_PERIOD < MIN_POLL_PERIOD) begin : g_bad_period
    $error("bp_poll_master: POLL_PERIOD too small");
  end
  if (READ_LATENCY < MIN_READ_LATENCY || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("bp_poll_master: READ_LATENCY out of range");
  end

  poll_state_t      state;
  poll_state_t      state_next;
  logic [TW-1:0]    timer;
  logic [LAT_W-1:0] lat_count;
  logic             tick;
  logic             capture;
  logic [NBTN-1:0]  sample;

  assign tick        = (timer == '0);
  assign sample      = avm_readdata[NBTN-1:0] ^ POLARITY;
  assign avm_address = ADDR_W'(BASE_ADDR);

  if (NBTN < 32) begin : g_unused
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:NBTN];
  end

  always_ff @(posedge clk) begin
    if (reset || tick) begin
      timer <= TIMER_RELOAD;
    end else begin
      timer <= timer - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (tick && enable) state_next = REQ;
      REQ:       if (!avm_waitrequest) state_next = WAIT_DATA;
      WAIT_DATA: if (lat_count == LAT_W'(1)) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    avm_read = 1'b0;
    capture  = 1'b0;
    case (state)
      REQ:       avm_read = 1'b1;
      WAIT_DATA: capture  = (lat_count == LAT_W'(1));
      default:   begin end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_count <= '0;
    end else if (state == REQ && !avm_waitrequest) begin
      lat_count <= LAT_LOAD;
    end else if (state == WAIT_DATA) begin
      lat_count <= lat_count - LAT_W'(1);
    end
  end

  // A tick that finds a transaction still in flight is lost, never queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= capture;
      if (tick && enable && state != IDLE) begin
        overrun <= 1'b1;
      end
    end
  end

  bp_debounce #(
    .NBTN           (NBTN),
    .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .strobe      (capture),
    .sample      (sample),
    .btn_state   (btn_state),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

endmodule

// File: doc/bp_poll_master.md
# bp_poll_master

Avalon-MM master that periodically reads the push-button PIO data register (offset 0, 32-bit readdata, 2 valid bits, registered read data). It is the initiator for that responder. Raw samples are debounced and converted to a pressed-state vector plus one-cycle press/release pulses, so fabric logic can consume button events without a Nios II processor in the loop. It sits between the Avalon interconnect master port and user logic.

## Interface
- POLL_PERIOD, 50000: clk cycles between poll launches (≥4).
- READ_LATENCY, 1: cycles from read acceptance to valid avm_readdata (1..4).
- DEBOUNCE_COUNT, 4: consecutive identical samples required to change state (2..255).
- BASE_ADDR, 0: word address driven on avm_address.
- ADDR_W, 2: avm_address width.
- NBTN, 2: button bits taken from avm_readdata[NBTN-1:0].
- ACTIVE_LOW, 1: 1 means raw 0 = pressed.
- clk  in  1  single clock; everything is synchronous to its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  enables poll launches.
- avm_address  out  ADDR_W  read address; constant BASE_ADDR.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data; bits ≥ NBTN ignored.
- btn_state  out  NBTN  debounced pressed state (1 = pressed).
- btn_press  out  NBTN  one-cycle pulse per bit on a 0→1 transition of btn_state.
- btn_release  out  NBTN  one-cycle pulse per bit on a 1→0 transition of btn_state.
- sample_valid  out  1  one-cycle pulse each time a sample is captured.
- overrun  out  1  sticky flag: a poll tick was dropped. Cleared only by reset.

## Operation
- FSM states: IDLE, REQ, WAIT_DATA.
- IDLE: avm_read=0. On a poll tick with enable=1, go to REQ.
- REQ: avm_read=1 and avm_address=BASE_ADDR, both held stable while avm_waitrequest=1. Acceptance is the cycle where avm_read=1 and avm_waitrequest=0. Then go to WAIT_DATA with the latency counter set to READ_LATENCY.
- WAIT_DATA: avm_read=0. Decrement the counter. When it expires:
  - capture avm_readdata[NBTN-1:0];
  - XOR with {NBTN{ACTIVE_LOW}} to form the logical sample;
  - pulse sample_valid;
  - return to IDLE.
- Timer: free-running down-counter that reloads POLL_PERIOD-1 when it reaches 0. A tick is generated when it reaches 0.
  - Tick while the FSM is not IDLE: tick dropped and overrun set. Ticks are never queued.
  - Tick with enable=0: tick ignored, no overrun.
- enable falling during REQ or WAIT_DATA: the transaction completes normally (Avalon requires read to be held until accepted). No further launches.
- Debounce, updated on each sample_valid:
  - sample ≠ candidate: candidate ← sample, count ← 1.
  - sample = candidate: count ← min(count+1, DEBOUNCE_COUNT).
  - When count reaches DEBOUNCE_COUNT and candidate ≠ btn_state: btn_state ← candidate. Press/release pulses are asserted in the same cycle per changed bit.
  - Multiple bits may change in the same cycle, each pulsing independently.
- Arithmetic: count width is clog2(DEBOUNCE_COUNT+1) and saturates, never wraps. Timer width is clog2(POLL_PERIOD).

## Timing
- Reset values:
  - avm_read=0; btn_state, btn_press, btn_release=0; sample_valid=0; overrun=0.
  - FSM=IDLE; candidate=0; count=0; timer=POLL_PERIOD-1.
- First tick occurs POLL_PERIOD cycles after the cycle in which reset is deasserted.
- Tick at cycle t with zero wait states:
  - avm_read=1 at t+1 (accepted);
  - sample captured at t+1+READ_LATENCY;
  - sample_valid and any btn_* change visible at t+2+READ_LATENCY.
- Reset asserted mid-transaction: avm_read drops on the next edge. Any in-flight readdata is discarded.
- Pulse outputs are exactly one cycle wide and are registered.
- sample_valid and btn_press/btn_release come from the same sample and assert in the same cycle.

## Structure
- Package bp_poll_pkg holds the state enum (IDLE, REQ, WAIT_DATA) and the minimum/maximum parameter-check constants.
- Sub-module bp_debounce (NBTN, DEBOUNCE_COUNT) holds candidate, count, btn_state and the edge pulses. Its input is the logical sample plus a strobe.
- The top level holds the timer, FSM, latency counter and polarity inversion.

## Test plan
Settings for all scenarios: POLL_PERIOD=8, READ_LATENCY=1, DEBOUNCE_COUNT=3, ACTIVE_LOW=1, responder model with registered readdata.
- Reset release, enable=1, waitrequest=0 → all outputs 0 during reset; first avm_read at cycle 8 after release; sample_valid at cycle 10; no overlapping reads.
- waitrequest held high for 5 cycles → avm_read and avm_address=BASE_ADDR stable for 6 cycles; exactly one acceptance; capture 1 cycle after acceptance.
- Raw in_port=2'b10 held steady → btn_state=2'b01 after the 3rd sample, btn_press=2'b01 for 1 cycle; raw back to 2'b11 for 3 samples → btn_release=2'b01 pulse, btn_state=0.
- Raw alternating 2'b10/2'b11 every poll → btn_state stays 0, no press/release pulses.
- waitrequest held 12 cycles → overrun=1 and stays 1 afterwards; only one read issued; normal polling resumes.
- enable dropped while in REQ → read completes with one sample_valid; no further reads while enable=0. Reset asserted in WAIT_DATA → no sample_valid, outputs return to reset values.
